prio_arbiter8: RTL and testbench

Sequential 8-requester arbiter with lockable grants. It shares a single downstream resource, such as a bus port or a shared datapath unit, among eight requesters. The winner is chosen by a selectable policy: fixed priority (highest bit index wins) or round-robin. Grants are registered and one-hot, are held until the owner releases, and can be pre-empted by a hold-time limit.

---
 rtl/prio_arbiter8.sv | 134 +++++++++++++
 tb/tb_prio_arbiter8.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter8.sv
// Eight-way arbiter with a registered one-hot grant that is held until the owner
// releases. Fixed-priority or round-robin choice, with an optional hold-time pre-emption.
module prio_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rr_mode,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid
);

    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);
    localparam bit PREEMPT_EN = (MAX_HOLD != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      gnt_q, gnt_d;
    logic [2:0]      id_q, id_d;
    logic [2:0]      last_q, last_d;
    logic            valid_q, valid_d;
    logic [HW-1:0]   hold_q, hold_d;

    logic [2:0]      fixed_w;
    logic [2:0]      rr_w;
    logic [2:0]      win;
    logic            owner_req;
    logic            contended;
    logic            hold_full;
    logic            drop_grant;

    // Highest set index wins; the zero-request case is never consumed.
    function automatic logic [2:0] pick_fixed(input logic [7:0] r);
        logic [2:0] w;
        w = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r[i]) w = 3'(i);
        end
        return w;
    endfunction

    // First set index scanning upward from last+1, wrapping modulo 8.
    function automatic logic [2:0] pick_rr(input logic [7:0] r, input logic [2:0] last);
        logic [2:0] w;
        logic [2:0] idx;
        logic       found;
        w     = 3'd0;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = last + 3'(i);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        fixed_w    = pick_fixed(req);
        rr_w       = pick_rr(req, last_q);
        win        = rr_mode ? rr_w : fixed_w;
        owner_req  = |(req & gnt_q);
        contended  = |(req & ~gnt_q);
        hold_full  = PREEMPT_EN && (hold_q == HOLD_MAX);
        drop_grant = !owner_req || (hold_full && contended);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        last_d  = last_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = 8'b1 << win;
                    id_d    = win;
                    last_d  = win;
                    valid_d = 1'b1;
                    hold_d  = HOLD_ONE;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // id_q stays at the last winner while idle.
                if (drop_grant) begin
                    gnt_d   = 8'd0;
                    valid_d = 1'b0;
                    hold_d  = '0;
                    state_d = IDLE;
                end else if (PREEMPT_EN && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 8'd0;
            id_q    <= 3'd0;
            last_q  <= 3'd7;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign gnt_valid = valid_q;

endmodule

// File: tb/tb_prio_arbiter8.sv
// Bench for prio_arbiter8: directed test-plan scenarios plus random traffic,
// with a cycle-level reference model feeding a scoreboard queue.
module tb_prio_arbiter8;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       rr_mode;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;

    int total;
    int bad;

    // Expected {gnt_valid, gnt_id, gnt} after each rising edge.
    logic [11:0] exp_q[$];

    prio_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rr_mode   (rr_mode),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner index (-1 when idle), cycles held, last winner.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 7;
    int m_id    = 0;

    always @(posedge clk) begin
        int w;
        logic [7:0] others;
        logic [7:0] exp_gnt;
        if (!rst_n) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = 7;
            m_id    = 0;
        end else if (m_owner < 0) begin
            if (req != 8'd0) begin
                w = -1;
                if (rr_mode) begin
                    for (int k = 1; k <= 8; k++) begin
                        if (w < 0 && req[(m_last + k) % 8]) w = (m_last + k) % 8;
                    end
                end else begin
                    for (int k = 7; k >= 0; k--) begin
                        if (w < 0 && req[k]) w = k;
                    end
                end
                m_owner = w;
                m_held  = 1;
                m_last  = w;
                m_id    = w;
            end
        end else begin
            others = req;
            others[m_owner] = 1'b0;
            if (!req[m_owner] || (MAX_HOLD > 0 && m_held >= MAX_HOLD && others != 8'd0)) begin
                m_owner = -1;
                m_held  = 0;
            end else if (m_held < MAX_HOLD) begin
                m_held = m_held + 1;
            end
        end
        exp_gnt = 8'd0;
        if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
        exp_q.push_back({(m_owner >= 0), 3'(m_id), exp_gnt});
    end

    // Monitor: pops one expectation per cycle, compares away from the edge.
    always @(negedge clk) begin
        logic [11:0] e;
        logic [11:0] a;
        a = {gnt_valid, gnt_id, gnt};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_empty: got %03h, no expectation queued", a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                bad++;
                $display("FAIL sb_cmp t=%0t: got valid=%0b id=%0d gnt=%08b, exp valid=%0b id=%0d gnt=%08b",
                         $time, a[11], a[10:8], a[7:0], e[11], e[10:8], e[7:0]);
            end
        end
        total++;
        if (!((gnt & (gnt - 8'd1)) == 8'd0 && gnt_valid === (|gnt))) begin
            bad++;
            $display("FAIL onehot_valid: gnt=%08b gnt_valid=%0b", gnt, gnt_valid);
        end
    end

    // Driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input logic [7:0] exp_gnt, input logic [2:0] exp_id);
        total++;
        if (gnt !== exp_gnt || gnt_valid !== (|exp_gnt) || gnt_id !== exp_id) begin
            bad++;
            $display("FAIL %s: got gnt=%08b id=%0d valid=%0b, exp gnt=%08b id=%0d",
                     name, gnt, gnt_id, gnt_valid, exp_gnt, exp_id);
        end
    endtask

    task automatic check_gnt(input string name, input logic [7:0] exp_gnt);
        total++;
        if (gnt !== exp_gnt || gnt_valid !== (|exp_gnt)) begin
            bad++;
            $display("FAIL %s: got gnt=%08b valid=%0b, exp gnt=%08b", name, gnt, gnt_valid, exp_gnt);
        end
    endtask

    initial begin
        int waited;
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        req     = 8'hFF;
        rr_mode = 1'b0;

        // Reset with all requests high, then fixed-priority first grant.
        step(2);
        check_now("reset_state", 8'h00, 3'd0);
        rst_n = 1'b1;
        step(1);
        check_now("post_reset_fixed", 8'h80, 3'd7);
        req = 8'h00;
        step(2);
        check_gnt("release_idle", 8'h00);

        // Fixed priority
        req = 8'b0001_0110;
        step(1);
        check_now("fixed_hi", 8'b0001_0000, 3'd4);
        req = 8'b0000_0110;
        step(1);
        check_now("fixed_gap", 8'h00, 3'd4);
        step(1);
        check_now("fixed_next", 8'b0000_0100, 3'd2);
        req = 8'h00;
        step(2);

        // Round-robin rotation from reset, all requesting
        rst_n = 1'b0;
        step(1);
        rst_n   = 1'b1;
        rr_mode = 1'b1;
        req     = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            step(1);
            check_now("rr_first", 8'(1 << (g % 8)), 3'(g % 8));
            step(MAX_HOLD - 1);
            check_now("rr_last", 8'(1 << (g % 8)), 3'(g % 8));
            step(1);
            check_gnt("rr_gap", 8'h00);
        end

        // Lone owner keeps the grant past MAX_HOLD; a rival forces release.
        rr_mode = 1'b0;
        req     = 8'h00;
        step(2);
        req = 8'h08;
        for (int c = 0; c < 10; c++) begin
            step(1);
            check_now("lone_owner", 8'h08, 3'd3);
        end
        req = 8'h28;
        step(1);
        check_gnt("preempt_drop", 8'h00);
        step(1);
        check_now("preempt_winner", 8'h20, 3'd5);
        req = 8'h00;
        step(2);

        // Mid-grant reset
        req = 8'h40;
        step(1);
        check_now("grant6", 8'h40, 3'd6);
        rst_n = 1'b0;
        step(1);
        check_now("mid_reset", 8'h00, 3'd0);
        rst_n   = 1'b1;
        rr_mode = 1'b1;
        req     = 8'h41;
        step(1);
        check_now("rr_after_reset", 8'h01, 3'd0);

        // Mode toggling during a grant leaves it untouched; fixed applies next.
        rr_mode = 1'b0;
        req     = 8'h83;
        step(1);
        check_now("mode_toggle_a", 8'h01, 3'd0);
        rr_mode = 1'b1;
        step(1);
        check_now("mode_toggle_b", 8'h01, 3'd0);
        rr_mode = 1'b0;
        waited  = 0;
        while (gnt_valid && waited < 10) begin
            step(1);
            waited++;
        end
        total++;
        if (gnt_valid) begin
            bad++;
            $display("FAIL preempt_timeout: grant still held after %0d cycles", waited);
        end
        step(1);
        check_now("new_policy_fixed", 8'h80, 3'd7);

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 3) == 0) req = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) rr_mode = ~rr_mode;
            step(1);
        end

        rst_n = 1'b1;
        req   = 8'h00;
        step(2);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
